// File: rtl/sinc_burst_controller.sv
// sinc_burst_controller: burst sequencer and pulse counter for the HFSWR sinc generator.
// Optional: define CFG_LIVE_UPDATE_EN to accept T/PRT updates mid-burst at period boundaries.
module sinc_burst_controller #(
  parameter int CNT_W   = 16,
  parameter int MIN_PRT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             sinc_in,
  output logic             gen_start,
  output logic [31:0]      gen_T,
  output logic [31:0]      gen_PRT,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             cfg_err,
  output logic [CNT_W-1:0] pulse_cnt
);

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  state_t state, state_nx;

  logic [31:0]      s_t;
  logic [31:0]      s_prt;
  logic [CNT_W-1:0] s_n;
  logic [CNT_W-1:0] n_act;
  logic             sinc_d;
  logic [31:0]      pc;

  logic rise, bnd, cfg_ok;
  logic accept, reject, stop, finish;
  logic shadow_we, cfg_drop, live_upd, live_bad;

  assign rise   = sinc_in & ~sinc_d;
  // B fires two cycles before the generator's wrap cycle
  assign bnd    = (pc == gen_PRT - 32'd3);
  assign cfg_ok = (s_t != 32'd0) &&
                  (s_prt >= 32'(MIN_PRT)) &&
                  (s_t < s_prt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    reject   = 1'b0;
    stop     = 1'b0;
    finish   = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_start && !cmd_stop) begin
          if (cfg_ok) begin
            accept   = 1'b1;
            state_nx = ARM;
          end else begin
            reject   = 1'b1;
          end
        end
      end
      ARM: begin
        if (cmd_stop) begin
          stop     = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if (cmd_stop) begin
          stop     = 1'b1;
          state_nx = IDLE;
        end else if (bnd && n_act != '0 &&
                     pulse_cnt == n_act) begin
          finish   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef CFG_LIVE_UPDATE_EN
  logic pend;
  logic at_b;

  assign shadow_we = cfg_we;
  assign cfg_drop  = 1'b0;
  assign at_b      = (state == RUN) && bnd && pend &&
                     !stop && !finish;
  assign live_upd  = at_b && cfg_ok;
  assign live_bad  = at_b && !cfg_ok;

  // a write landing on the update cycle stays pending
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    pend <= 1'b0;
    else if (cfg_we && busy)     pend <= 1'b1;
    else if (live_upd || accept) pend <= 1'b0;
  end
`else
  assign shadow_we = cfg_we & ~busy;
  assign cfg_drop  = cfg_we & busy;
  assign live_upd  = 1'b0;
  assign live_bad  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_t       <= '0;
      s_prt     <= '0;
      s_n       <= '0;
      n_act     <= '0;
      sinc_d    <= 1'b0;
      pc        <= '0;
      gen_start <= 1'b0;
      gen_T     <= '0;
      gen_PRT   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      cfg_err   <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      sinc_d  <= sinc_in;
      done    <= finish;
      aborted <= stop;

      if (rise)                      pc <= '0;
      else if (pc != 32'hFFFF_FFFF)  pc <= pc + 32'd1;

      if (shadow_we) begin
        case (cfg_addr)
          2'd0:    s_t   <= cfg_wdata;
          2'd1:    s_prt <= cfg_wdata;
          2'd2:    s_n   <= cfg_wdata[CNT_W-1:0];
          default: ;
        endcase
      end

      if (accept) begin
        gen_T     <= s_t;
        gen_PRT   <= s_prt;
        n_act     <= s_n;
        busy      <= 1'b1;
        pulse_cnt <= '0;
        cfg_err   <= 1'b0;
      end else if (state == RUN && rise && !cmd_stop) begin
        pulse_cnt <= pulse_cnt + 1'b1;
      end

      if (live_upd) begin
        gen_T   <= s_t;
        gen_PRT <= s_prt;
        n_act   <= s_n;
      end

      if (state == ARM && !cmd_stop) gen_start <= 1'b1;

      if (stop || finish) begin
        gen_start <= 1'b0;
        busy      <= 1'b0;
      end

      if (reject || cfg_drop || live_bad) cfg_err <= 1'b1;
    end
  end

endmodule
